// File: rtl/gesture_pkg.sv
// Shared types for the pitch gesture detector: FSM state encoding and latched direction.
package gesture_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_HELD    = 3'd2,
        S_REPEAT  = 3'd3,
        S_HOLDOFF = 3'd4
    } gesture_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pitch_gesture_detector.sv
// Turns held high/low pitch flags into debounced up/down pulses with auto-repeat
// and a refractory holdoff after release. One shared counter times every phase.
module pitch_gesture_detector
    import gesture_pkg::*;
#(
    parameter int STABLE_CYCLES  = 100_000,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_PERIOD  = 20_000_000,
    parameter int HOLDOFF_CYCLES = 10_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic       hi_in,
    input  logic       lo_in,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [2:0] state_out,
    output logic [7:0] event_count
);

    localparam int CNT_W = $clog2(max_of4(STABLE_CYCLES, REPEAT_DELAY,
                                          REPEAT_PERIOD, HOLDOFF_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    gesture_state_t   r_state, w_state_next;
    dir_t             r_dir, w_dir_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_up, r_down;
    logic [7:0]       r_events;

    logic w_sel, w_opp, w_release, w_emit;

    // Release is judged against the direction latched on entry to QUALIFY.
    assign w_sel     = (r_dir == DIR_UP) ? hi_in : lo_in;
    assign w_opp     = (r_dir == DIR_UP) ? lo_in : hi_in;
    assign w_release = !w_sel || w_opp;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_IDLE;
            r_dir    <= DIR_UP;
            r_cnt    <= '0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_events <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_dir    <= w_dir_next;
            r_cnt    <= w_cnt_next;
            r_up     <= w_emit && (r_dir == DIR_UP);
            r_down   <= w_emit && (r_dir == DIR_DOWN);
            r_events <= r_events + {7'd0, w_emit};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_cnt_next   = r_cnt;
        w_emit       = 1'b0;

        if (!enable_in) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hi_in ^ lo_in) begin
                        w_dir_next   = hi_in ? DIR_UP : DIR_DOWN;
                        w_cnt_next   = CNT_W'(1);
                        w_state_next = S_QUALIFY;
                    end
                end
                S_QUALIFY: begin
                    if (w_release) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_emit       = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_HELD;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                S_HELD, S_REPEAT: begin
                    // Release is checked first so it beats a coincident repeat pulse.
                    if (w_release) begin
                        w_state_next = S_HOLDOFF;
                        w_cnt_next   = '0;
                    end else if (r_cnt == ((r_state == S_HELD) ? DELAY_LAST : PERIOD_LAST)) begin
                        w_emit       = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_REPEAT;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt == HOLDOFF_LAST) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign up_pulse    = r_up;
    assign down_pulse  = r_down;
    assign state_out   = r_state;
    assign event_count = r_events;

endmodule

// File: tb/tb_pitch_gesture_detector.sv
// Directed bench for pitch_gesture_detector with small timing parameters.
module tb_pitch_gesture_detector;

    localparam int ST = 4, RD = 20, RP = 10, HO = 8;

    logic       clk_in    = 1'b0;
    logic       rst_in    = 1'b1;
    logic       enable_in = 1'b0;
    logic       hi_in     = 1'b0;
    logic       lo_in     = 1'b0;
    logic       up_pulse, down_pulse;
    logic [2:0] state_out;
    logic [7:0] event_count;

    pitch_gesture_detector #(
        .STABLE_CYCLES (ST),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .enable_in  (enable_in),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .state_out  (state_out),
        .event_count(event_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       hi, lo, en;
        logic       up, dn;
        logic [2:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic h, input logic l, input logic en);
        hi_in     = h;
        lo_in     = l;
        enable_in = en;
        @(posedge clk_in);
        #1;
    endtask

    task automatic add(input logic h, input logic l, input logic en, input logic up,
                       input logic dn, input logic [2:0] st, input logic [7:0] cnt, input int rep);
        vec_t v;
        v.hi = h; v.lo = l; v.en = en; v.up = up; v.dn = dn; v.st = st; v.cnt = cnt;
        for (int i = 0; i < rep; i++) vq.push_back(v);
    endtask

    task automatic drain_holdoff(input string name);
        for (int i = 0; i < HO - 1; i++) step(1'b0, 1'b0, 1'b1);
        chk({name, ".still_holdoff"}, state_out, 4);
        step(1'b0, 1'b0, 1'b1);
        chk({name, ".idle"}, state_out, 0);
    endtask

    initial begin
        int exp_cnt;
        logic exp_up;
        int pulses;

        // hi for 4 edges then release: pulse on edge 4, IDLE after 8 holdoff edges
        add(1,0,1, 0,0,1,0, 3);
        add(1,0,1, 1,0,2,1, 1);
        add(0,0,1, 0,0,4,1, 8);
        add(0,0,1, 0,0,0,1, 1);
        // lo for 3 edges: aborted qualify
        add(0,1,1, 0,0,1,1, 3);
        add(0,0,1, 0,0,0,1, 1);
        // down gesture, released by opposite input; inputs ignored in holdoff
        add(0,1,1, 0,0,1,1, 3);
        add(0,1,1, 0,1,2,2, 1);
        add(1,1,1, 0,0,4,2, 1);
        add(1,0,1, 0,0,4,2, 7);
        add(1,0,1, 0,0,0,2, 1);
        add(0,0,1, 0,0,0,2, 1);
        // both high: never leaves IDLE
        add(1,1,1, 0,0,0,2, 10);
        add(0,0,1, 0,0,0,2, 1);
        // opposite input during qualify aborts
        add(1,0,1, 0,0,1,2, 2);
        add(1,1,1, 0,0,0,2, 1);
        add(0,0,1, 0,0,0,2, 1);
        // enable low on the would-be pulse edge suppresses it
        add(1,0,1, 0,0,1,2, 3);
        add(1,0,0, 0,0,0,2, 1);
        add(1,0,1, 0,0,1,2, 3);
        add(1,0,0, 0,0,0,2, 1);
        add(0,0,1, 0,0,0,2, 1);

        // asynchronous reset before any clock edge
        #2 rst_in = 1'b0;
        #1;
        chk("rst.up", up_pulse, 0);
        chk("rst.down", down_pulse, 0);
        chk("rst.state", state_out, 0);
        chk("rst.count", event_count, 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        rst_in = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].hi, vq[i].lo, vq[i].en);
            chk($sformatf("vec%0d.up", i), up_pulse, vq[i].up);
            chk($sformatf("vec%0d.down", i), down_pulse, vq[i].dn);
            chk($sformatf("vec%0d.state", i), state_out, vq[i].st);
            chk($sformatf("vec%0d.count", i), event_count, vq[i].cnt);
        end
        exp_cnt = 2;

        // auto-repeat: pulses at edges 4, 24, 34, 44, 54
        for (int e = 1; e <= 60; e++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_up = (e == 4 || e == 24 || e == 34 || e == 44 || e == 54);
            chk($sformatf("rep.e%0d.up", e), up_pulse, exp_up);
            chk($sformatf("rep.e%0d.down", e), down_pulse, 0);
        end
        exp_cnt += 5;
        chk("rep.count", event_count, exp_cnt);
        step(1'b0, 1'b0, 1'b1);
        chk("rep.release", state_out, 4);
        drain_holdoff("rep");

        // release on the same edge as the first repeat: release wins
        for (int e = 1; e <= 23; e++) step(1'b1, 1'b0, 1'b1);
        exp_cnt += 1;
        step(1'b0, 1'b0, 1'b1);
        chk("coll.up", up_pulse, 0);
        chk("coll.state", state_out, 4);
        chk("coll.count", event_count, exp_cnt);
        drain_holdoff("coll");

        // re-press during holdoff: next pulse only 4 edges after holdoff ends
        for (int e = 1; e <= 4; e++) step(1'b1, 1'b0, 1'b1);
        chk("hold.first", up_pulse, 1);
        exp_cnt += 1;
        step(1'b0, 1'b0, 1'b1);
        for (int e = 6; e <= 17; e++) begin
            step(1'b1, 1'b0, 1'b1);
            chk($sformatf("hold.e%0d.up", e), up_pulse, (e == 17));
        end
        exp_cnt += 1;
        chk("hold.count", event_count, exp_cnt);
        step(1'b0, 1'b0, 1'b1);
        drain_holdoff("hold");

        // reset mid-qualify discards pending pulse
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        #2 rst_in = 1'b0;
        #1;
        chk("rstq.state", state_out, 0);
        chk("rstq.count", event_count, 0);
        @(posedge clk_in); #1;
        chk("rstq.held_up", up_pulse, 0);
        rst_in = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step(1'b1, 1'b0, 1'b1);
            chk($sformatf("rstq.e%0d.up", e), up_pulse, (e == 4));
        end
        // reset while a pulse is high clears it without a clock edge
        #2 rst_in = 1'b0;
        #1;
        chk("rstp.up", up_pulse, 0);
        chk("rstp.count", event_count, 0);
        chk("rstp.state", state_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        // 256 pulses: 256th lands on edge 24 + 254*10 = 2564 and wraps the count
        pulses = 0;
        for (int e = 1; e <= 2564; e++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_up = (e == 4) || (e >= 24 && ((e - 24) % 10) == 0);
            if (exp_up) pulses++;
            chk($sformatf("wrap.e%0d.up", e), up_pulse, exp_up);
            if (exp_up || e == 2563)
                chk($sformatf("wrap.e%0d.count", e), event_count, pulses % 256);
        end
        chk("wrap.final", event_count, 0);
        step(1'b0, 1'b0, 1'b1);
        drain_holdoff("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pitch_gesture_detector.md
PITCH_GESTURE_DETECTOR -- requirements
Module: pitch_gesture_detector

Interface
REQ-001 Parameter STABLE_CYCLES, default 100_000, is the number of consecutive samples a direction must be held to qualify; legal range is 2 or more.
REQ-002 Parameter REPEAT_DELAY, default 50_000_000, is the number of cycles from the first pulse to the first auto-repeat pulse; legal range is 1 or more.
REQ-003 Parameter REPEAT_PERIOD, default 20_000_000, is the number of cycles between auto-repeat pulses; legal range is 1 or more.
REQ-004 Parameter HOLDOFF_CYCLES, default 10_000_000, is the refractory time after release, during which inputs are ignored; legal range is 1 or more.
REQ-005 The module SHALL have exactly one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-006 clk_in  input  1  system clock, 100 MHz.
REQ-007 rst_in  input  1  asynchronous, active-low reset.
REQ-008 enable_in  input  1  when low, detection is disabled.
REQ-009 hi_in  input  1  high-pitch flag, already synchronized to clk_in.
REQ-010 lo_in  input  1  low-pitch flag, already synchronized to clk_in.
REQ-011 up_pulse  output  1  registered one-cycle "up" event.
REQ-012 down_pulse  output  1  registered one-cycle "down" event.
REQ-013 state_out  output  3  current FSM state encoding, for debug.
REQ-014 event_count  output  8  count of emitted pulses, wrapping at 255 to 0.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, QUALIFY, HELD, REPEAT and HOLDOFF.
REQ-016 A single counter SHALL be used, with width $clog2 of the largest parameter plus 1.
REQ-017 IDLE: when exactly one of hi_in/lo_in is high at an edge, the FSM SHALL latch that direction, set cnt=1 and go to QUALIFY.
REQ-018 IDLE: when both inputs are high, or neither is, the FSM SHALL stay in IDLE.
REQ-019 QUALIFY: if the latched input is low, or the opposite input is high, at an edge, the FSM SHALL return to IDLE with no pulse.
REQ-020 QUALIFY: if cnt==STABLE_CYCLES-1, the FSM SHALL assert the direction pulse, set cnt=0 and go to HELD; otherwise it SHALL increment cnt.
REQ-021 Latency: an input held high at STABLE_CYCLES consecutive edges SHALL cause the pulse register to go high at the STABLE_CYCLES-th edge and stay high for exactly one cycle.
REQ-022 HELD: on cnt==REPEAT_DELAY-1 the FSM SHALL emit a pulse, set cnt=0 and go to REPEAT.
REQ-023 REPEAT: on cnt==REPEAT_PERIOD-1 the FSM SHALL emit a pulse and set cnt=0.
REQ-024 Release in HELD or REPEAT (latched input low, or opposite input high) SHALL take the FSM to HOLDOFF with cnt=0.
REQ-025 If release and a repeat pulse fall on the same edge, release SHALL win and no pulse SHALL be emitted.
REQ-026 HOLDOFF SHALL ignore both inputs, and on cnt==HOLDOFF_CYCLES-1 SHALL go to IDLE.
REQ-027 up_pulse and down_pulse SHALL never be high in the same cycle.
REQ-028 event_count SHALL increment on every emitted pulse, wrapping from 255 to 0.
REQ-029 enable_in low at any edge SHALL force the FSM to IDLE, set cnt=0 and suppress the pulse for that edge.
REQ-030 enable_in low SHALL leave event_count unchanged.
REQ-031 State encoding on state_out SHALL be IDLE=0, QUALIFY=1, HELD=2, REPEAT=3, HOLDOFF=4.

Reset
REQ-032 rst_in low SHALL immediately, without waiting for a clock edge, set state IDLE, cnt 0, latched direction "up", up_pulse 0, down_pulse 0 and event_count 0.
REQ-033 A reset asserted mid-qualify or mid-repeat SHALL discard any pending pulse.
REQ-034 The first qualification after reset deassertion SHALL start only from IDLE.

Structure
REQ-035 Package gesture_pkg SHALL hold the gesture_state_t enum (with the REQ-031 encoding) and the dir_t type (DIR_UP/DIR_DOWN).
REQ-036 The FSM, counter and output registers SHALL live in the single module; no sub-module is needed.
REQ-037 The outputs SHALL drive the menu and game_controller up/down inputs directly, with no further edge detection.

Verification (bench parameters STABLE=4, REPEAT_DELAY=20, REPEAT_PERIOD=10, HOLDOFF=8)
REQ-038 hi_in high for 4 edges, then low -> exactly one up_pulse at edge 4, event_count=1, state returns to IDLE after 8 holdoff cycles.
REQ-039 lo_in high for 3 edges, then low -> no pulse, state returns to IDLE, event_count stays 0.
REQ-040 hi_in held for 60 edges -> up_pulses at edges 4, 24, 34, 44, 54 (five in total).
REQ-041 hi_in and lo_in both high for 10 edges -> no pulses, state stays IDLE.
REQ-042 hi_in pulse, release, then hi_in high again during holdoff -> no second pulse until after HOLDOFF completes and 4 fresh edges are seen.
REQ-043 rst_in low at edge 3 of qualify, and 256 pulses issued -> no pulse after the reset, all outputs 0 asynchronously; event_count wraps from 255 to 0.
